// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 transmitter bank: frame states and the parity helper.
package ps2_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      BIT0   = 4'd1,
      BIT1   = 4'd2,
      BIT2   = 4'd3,
      BIT3   = 4'd4,
      BIT4   = 4'd5,
      BIT5   = 4'd6,
      BIT6   = 4'd7,
      BIT7   = 4'd8,
      PARITY = 4'd9,
      STOP   = 4'd10,
      DONE   = 4'd11
   } ps2_state_e;

   localparam int FRAME_LEN = 11;

   // Odd parity: the parity bit makes the total count of ones in data+parity odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_tx_bank_if.sv
// Host-side bundle of the PS/2 transmitter bank: per-channel write/control strobes and status.
interface ps2_tx_bank_if #(
   parameter int CHANNELS  = 2,
   parameter int FIFO_BITS = 3
);
   logic [CHANNELS-1:0]               wr;
   logic [8*CHANNELS-1:0]             din;
   logic [CHANNELS-1:0]               flush;
   logic [CHANNELS-1:0]               clr_ovf;
   logic [CHANNELS-1:0]               inhibit;
   logic [CHANNELS-1:0]               full;
   logic [(FIFO_BITS+1)*CHANNELS-1:0] level;
   logic [CHANNELS-1:0]               overflow;
   logic [CHANNELS-1:0]               busy;
   logic [CHANNELS-1:0]               ps2_clk;
   logic [CHANNELS-1:0]               ps2_data;

   modport master (
      output wr, din, flush, clr_ovf, inhibit,
      input  full, level, overflow, busy, ps2_clk, ps2_data
   );

   modport slave (
      input  wr, din, flush, clr_ovf, inhibit,
      output full, level, overflow, busy, ps2_clk, ps2_data
   );
endinterface

// File: rtl/ps2_tx_chan.sv
// One PS/2 device-side transmit channel: byte FIFO with level/overflow status and frame FSM.
//   state       | meaning
//   IDLE        | line released, waiting for a queued byte and no inhibit
//   BIT0..BIT7  | drive the next data bit, LSB first
//   PARITY      | drive the odd parity bit
//   STOP        | drive the stop bit (1)
//   DONE        | frame complete, pop the head byte
module ps2_tx_chan
   import ps2_pkg::*;
#(
   parameter int FIFO_BITS = 3
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 clk_ps2,
   input  logic                 wr,
   input  logic [7:0]           din,
   input  logic                 flush,
   input  logic                 clr_ovf,
   input  logic                 inhibit,
   output logic                 full,
   output logic [FIFO_BITS:0]   level,
   output logic                 overflow,
   output logic                 busy,
   output logic                 ps2_clk,
   output logic                 ps2_data
);
   localparam int DEPTH = 1 << FIFO_BITS;

   logic [7:0]           mem [DEPTH];
   logic [FIFO_BITS-1:0] wptr, rptr;
   ps2_state_e           st, st_nxt;
   logic [7:0]           shift, shift_nxt;
   logic                 parity, parity_nxt, data_nxt;
   logic                 push, pop;

   assign full    = (level == (FIFO_BITS+1)'(DEPTH));
   assign push    = wr && !full && !flush;
   assign busy    = (st != IDLE);
   assign ps2_clk = clk_ps2 | (st == IDLE);

   always_comb begin
      st_nxt     = st;
      shift_nxt  = shift;
      parity_nxt = parity;
      data_nxt   = ps2_data;
      pop        = 1'b0;
      // Abort is immediate; the head byte stays queued so the frame is resent whole.
      if (flush || (inhibit && st != IDLE)) begin
         st_nxt   = IDLE;
         data_nxt = 1'b1;
      end else if (tick) begin
         case (st)
            IDLE: begin
               if (level != '0 && !inhibit) begin
                  shift_nxt  = mem[rptr];
                  parity_nxt = odd_parity(mem[rptr]);
                  data_nxt   = 1'b0;
                  st_nxt     = BIT0;
               end
            end
            BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
               data_nxt  = shift[0];
               shift_nxt = {1'b0, shift[7:1]};
               st_nxt    = ps2_state_e'(st + 4'd1);
            end
            PARITY: begin
               data_nxt = parity;
               st_nxt   = STOP;
            end
            STOP: begin
               data_nxt = 1'b1;
               st_nxt   = DONE;
            end
            DONE: begin
               pop    = 1'b1;
               st_nxt = IDLE;
            end
            default: begin
               data_nxt = 1'b1;
               st_nxt   = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         st       <= IDLE;
         shift    <= '0;
         parity   <= 1'b0;
         ps2_data <= 1'b1;
      end else begin
         st       <= st_nxt;
         shift    <= shift_nxt;
         parity   <= parity_nxt;
         ps2_data <= data_nxt;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + FIFO_BITS'(1);
         if (pop)  rptr <= rptr + FIFO_BITS'(1);
         case ({push, pop})
            2'b10:   level <= level + (FIFO_BITS+1)'(1);
            2'b01:   level <= level - (FIFO_BITS+1)'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem[wptr] <= din;
   end

   // A dropped write outranks a coincident clear.
   always_ff @(posedge clk_sys) begin
      if (reset)                        overflow <= 1'b0;
      else if (wr && full && !flush)    overflow <= 1'b1;
      else if (clr_ovf)                 overflow <= 1'b0;
   end

endmodule

// File: rtl/ps2_tx_bank.sv
// Bank of independent PS/2 transmit channels sharing one PS/2 clock divider and tick.
module ps2_tx_bank #(
   parameter int CHANNELS  = 2,
   parameter int FIFO_BITS = 3,
   parameter int PS2DIV    = 1000
) (
   input  logic          clk_sys,
   input  logic          reset,
   ps2_tx_bank_if.slave  bus
);
   localparam int CW = $clog2(PS2DIV + 1);
   localparam int LW = FIFO_BITS + 1;

   logic [CW-1:0]          cnt;
   logic                   clk_ps2, clk_ps2_d, tick;
   logic [CHANNELS-1:0]    full_w, ovf_w, busy_w, pclk_w, pdata_w;
   logic [LW*CHANNELS-1:0] level_w;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt       <= '0;
         clk_ps2   <= 1'b0;
         clk_ps2_d <= 1'b0;
      end else begin
         clk_ps2_d <= clk_ps2;
         if (cnt == CW'(PS2DIV)) begin
            cnt     <= '0;
            clk_ps2 <= ~clk_ps2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // High for the one cycle after clk_ps2 rises; channels shift their next bit then.
   assign tick = clk_ps2 & ~clk_ps2_d;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      ps2_tx_chan #(.FIFO_BITS(FIFO_BITS)) u_chan (
         .clk_sys  (clk_sys),
         .reset    (reset),
         .tick     (tick),
         .clk_ps2  (clk_ps2),
         .wr       (bus.wr[c]),
         .din      (bus.din[8*c +: 8]),
         .flush    (bus.flush[c]),
         .clr_ovf  (bus.clr_ovf[c]),
         .inhibit  (bus.inhibit[c]),
         .full     (full_w[c]),
         .level    (level_w[LW*c +: LW]),
         .overflow (ovf_w[c]),
         .busy     (busy_w[c]),
         .ps2_clk  (pclk_w[c]),
         .ps2_data (pdata_w[c])
      );
   end

   assign bus.full     = full_w;
   assign bus.level    = level_w;
   assign bus.overflow = ovf_w;
   assign bus.busy     = busy_w;
   assign bus.ps2_clk  = pclk_w;
   assign bus.ps2_data = pdata_w;

endmodule

// File: doc/ps2_tx_bank.md
Name: ps2_tx_bank

Overview:
- Parametrised PS/2 device-side transmitter bank: N independent channels (keyboard, mouse, extra pads), each with a byte FIFO and a serial frame generator.
- All channels share one PS/2 clock divider.
- Fed from the HPS command decoder, one write strobe per channel.
- Adds behaviour not previously present: FIFO full/level reporting, sticky overflow, per-channel flush, and host-inhibit abort with retransmit.

Parameters:
- CHANNELS, 2, number of independent PS/2 channels (1..8).
- FIFO_BITS, 3, log2 FIFO depth per channel; depth = 2^FIFO_BITS.
- PS2DIV, 1000, divider terminal count; PS/2 clock period = 2*(PS2DIV+1) clk_sys cycles.

Ports:
- clk_sys  in  1  system clock; all logic posedge.
- reset  in  1  synchronous, active-high reset.
- wr  in  CHANNELS  per-channel write strobe, one byte per high cycle.
- din  in  8*CHANNELS  write data; channel c = din[8c+7:8c].
- flush  in  CHANNELS  clears the FIFO and aborts the frame on the next edge.
- clr_ovf  in  CHANNELS  clears the sticky overflow flag.
- inhibit  in  CHANNELS  host holds the clock low; blocks or aborts transmission.
- full  out  CHANNELS  FIFO holds 2^FIFO_BITS bytes.
- level  out  (FIFO_BITS+1)*CHANNELS  bytes stored, including the byte in flight.
- overflow  out  CHANNELS  sticky; set when a write is dropped because the FIFO is full.
- busy  out  CHANNELS  frame in progress (tx state != IDLE).
- ps2_clk  out  CHANNELS  PS/2 clock = shared clk_ps2 OR idle.
- ps2_data  out  CHANNELS  PS/2 data line.

Behaviour:
- Reset values:
  - Divider: cnt=0, clk_ps2=0, tick=0.
  - Per channel: tx state IDLE, FIFO pointers 0, level=0, full=0, overflow=0, busy=0, ps2_data=1, ps2_clk=1.
- Divider:
  - cnt increments every cycle. At cnt==PS2DIV, clk_ps2 toggles and cnt returns to 0.
  - tick is a one-cycle pulse on the cycle after clk_ps2 goes 0->1 (registered edge detect).
  - All channel state machines advance only on tick.
- FIFO:
  - Write when wr[c]=1 and full[c]=0: din is stored at wptr, wptr+1 (wraps modulo depth), level+1.
  - Write when full[c]=1 is dropped and sets overflow[c]. This holds even if a pop occurs in the same cycle.
  - Pop happens only on frame completion (see below). A write and a pop in the same non-full cycle leave level unchanged.
  - Empty: wptr==rptr with level==0. Pointers carry no extra bit; level disambiguates full from empty.
- Frame state machine, per channel, advancing on tick:
  - IDLE: if level>0 and inhibit=0, load shift register from FIFO head (no pop), parity=1, ps2_data=0 (start bit), go to BIT0.
  - BIT0..BIT7: ps2_data = shift[0]; shift right; parity ^= shift[0]. Data is sent LSB first with odd parity.
  - PARITY: ps2_data = parity.
  - STOP: ps2_data = 1.
  - DONE: pop the FIFO head (rptr+1, level-1), go to IDLE.
- ps2_clk[c] = clk_ps2 | (state==IDLE).
- Latency: a byte written into an empty, idle channel drives its start bit at the first tick after the write.
- Inhibit:
  - inhibit=1 in IDLE blocks the start of a frame.
  - inhibit=1 in any other state, on any cycle (not only on tick), forces IDLE and ps2_data=1. The head byte is not popped.
  - The frame restarts from the start bit at the first tick with inhibit=0.
- Flush:
  - Forces IDLE, ps2_data=1, rptr=wptr=0, level=0.
  - flush together with wr in the same cycle: flush wins, the write is discarded, overflow is unchanged.
- Overflow flag:
  - clr_ovf clears overflow. If a set condition and clr_ovf coincide, set wins.
- Channel independence:
  - Channels share only tick. Any combination of simultaneous events on different channels is independent.
- Reset mid-frame: returns to the reset values immediately on the next edge; the byte in flight is lost.

Decomposition:
- Package ps2_pkg holds:
  - Frame state localparams: IDLE=0, BIT0=1..BIT7=8, PARITY=9, STOP=10, DONE=11 (4-bit encoding).
  - FRAME_LEN=11.
  - An odd-parity function.
- Sub-module ps2_tx_chan: one channel, containing the FIFO, level/full/overflow logic and the frame FSM.
- ps2_tx_bank holds the shared divider/tick generator and a generate loop over CHANNELS.

Test Plan (PS2DIV=3, FIFO_BITS=2, CHANNELS=2):
- Single byte: write 0x1C to ch0 -> ps2_data, sampled at each ps2_clk rise, reads 0, 0,0,1,1,1,0,0,0, parity 0, stop 1; ps2_clk held high before and after; level 1->0 at DONE; busy low afterwards.
- Parity edges: bytes 0x00 then 0xFF -> parity bits 1 and 1; frames are back to back with exactly one IDLE tick between them.
- Overflow: 5 writes to ch1 with no ticks (inhibit=1) -> full=1 and level=4 after the 4th write; the 5th write is dropped and sets overflow=1; clr_ovf clears it; clr_ovf together with another full write leaves overflow=1.
- Inhibit abort: assert inhibit[0] while ch0 is sending BIT3 of 0xA5 -> ps2_data=1, busy=0, level stays 1; after release the full 0xA5 frame is retransmitted from the start bit.
- Flush precedence: flush[0] with wr[0]=1 (din 0x55) while 3 bytes are queued -> level=0, no frame starts, overflow unchanged.
- Independence and reset: ch0 sending 0x12 while ch1 sends 0x34 -> both frames are correct and aligned to the same ticks. Reset asserted at ch0 BIT5 -> all outputs take their reset values on the next edge.
